// File: rtl/powerup_timer_bank_if.sv
// powerup_timer_bank_if: collection/control inputs and status outputs of the power-up timer bank.
//   master: eaten, mode, pause, clear_all driven; pp_status, expire_pulse, remaining observed
//   slave : the timer bank, the reverse directions
interface powerup_timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 4
) ();
  logic                    eaten;
  logic [CH_W-1:0]         mode;
  logic                    pause;
  logic                    clear_all;
  logic [NUM_CH-1:0]       pp_status;
  logic [NUM_CH-1:0]       expire_pulse;
  logic [NUM_CH*CNT_W-1:0] remaining;
  modport master (output eaten, mode, pause, clear_all, input pp_status, expire_pulse, remaining);
  modport slave  (input eaten, mode, pause, clear_all, output pp_status, expire_pulse, remaining);
endinterface

// File: rtl/powerup_timer_bank.sv
// powerup_timer_bank: NUM_CH power-up duration timers sharing one tick prescaler.
//   clk, reset (async, active-low); bus (slave): eaten/mode load a channel, pause freezes
//   counting, clear_all cancels all; pp_status/expire_pulse/remaining report per channel.
//   Build option POWERUP_EXTEND_EN: re-eat of an active channel adds its duration
//   (saturating) instead of reloading it.
module powerup_timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 4,
  parameter int PRESCALER = 64999999,
  parameter int PS_W      = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DUR_FLAT = {4'd4, 4'd5, 4'd2, 4'd3}
) (
  input logic clk,
  input logic reset,
  powerup_timer_bank_if.slave bus
);
`ifdef POWERUP_EXTEND_EN
  localparam bit EXTEND = 1'b1;
`else
  localparam bit EXTEND = 1'b0;
`endif
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t            st_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] exp_q, exp_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              tick;
  always_comb begin
    tick = ps_q == PS_W'(PRESCALER) && !bus.pause;
    ps_d = bus.pause ? ps_q : ps_q == PS_W'(PRESCALER) ? '0 : ps_q + 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      // one extra bit so the extension can detect overflow and saturate
      sum[i]   = {1'b0, cnt_q[i]} + {1'b0, DUR_FLAT[i*CNT_W +: CNT_W]};
      load[i]  = bus.eaten && bus.mode == CH_W'(i) && !bus.clear_all && DUR_FLAT[i*CNT_W +: CNT_W] != '0;
      cnt_d[i] = bus.clear_all ? '0 :
                 load[i] ? (EXTEND && st_q[i] == ACTIVE ? (sum[i][CNT_W] ? '1 : sum[i][CNT_W-1:0])
                                                         : DUR_FLAT[i*CNT_W +: CNT_W]) :
                 tick && st_q[i] == ACTIVE ? cnt_q[i] - 1'b1 : cnt_q[i];
      // a load or clear on the expiring edge suppresses the pulse
      exp_d[i] = !bus.clear_all && !load[i] && tick && cnt_q[i] == CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q  <= '0;
      exp_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
    end else begin
      ps_q  <= ps_d;
      exp_q <= exp_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= cnt_d[i] != '0 ? ACTIVE : IDLE;
      end
    end
  end
  assign bus.expire_pulse = exp_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.pp_status[g] = st_q[g] == ACTIVE;
    assign bus.remaining[g*CNT_W +: CNT_W] = cnt_q[g];
  end
endmodule

// File: tb/tb_powerup_timer_bank.sv
// tb_powerup_timer_bank: scoreboard bench; a spec-level model pushes expected outputs per edge.
module tb_powerup_timer_bank;
  localparam int NUM_CH = 4, CH_W = 2, CNT_W = 4, PRESCALER = 3;
`ifdef POWERUP_EXTEND_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  typedef struct {
    logic [3:0]  pp;
    logic [3:0]  ex;
    logic [15:0] rem;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  powerup_timer_bank_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();
  powerup_timer_bank #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .PRESCALER(PRESCALER), .PS_W(2),
    .DUR_FLAT({4'd4, 4'd5, 4'd2, 4'd3})
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int m_ps;
  int m_cnt[4];
  int dur[4] = '{3, 2, 5, 4};
  logic [3:0] held;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic model_reset();
    m_ps = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask
  task automatic step();
    exp_t e;
    bit t;
    t = m_ps == PRESCALER && !bus.pause;
    if (!bus.pause) m_ps = m_ps == PRESCALER ? 0 : m_ps + 1;
    e.ex = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.clear_all) m_cnt[i] = 0;
      else if (bus.eaten && int'(bus.mode) == i && dur[i] != 0)
        m_cnt[i] = (EXT && m_cnt[i] > 0) ? ((m_cnt[i] + dur[i] > 15) ? 15 : m_cnt[i] + dur[i]) : dur[i];
      else if (t && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        e.ex[i] = m_cnt[i] == 0;
      end
      e.pp[i] = m_cnt[i] != 0;
      e.rem[i*4 +: 4] = 4'(m_cnt[i]);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("pp_status", 32'(bus.pp_status), 32'(e.pp));
    check("expire_pulse", 32'(bus.expire_pulse), 32'(e.ex));
    check("remaining", 32'(bus.remaining), 32'(e.rem));
  endtask
  task automatic drive(input logic e, input logic [1:0] m, input logic c);
    bus.eaten = e;
    bus.mode = m;
    bus.clear_all = c;
  endtask
  task automatic run(input int n);
    drive(1'b0, 2'd0, 1'b0);
    repeat (n) step();
  endtask
  initial begin
    drive(1'b0, 2'd0, 1'b0);
    bus.pause = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pp", 32'(bus.pp_status), 32'd0);
    check("reset_ex", 32'(bus.expire_pulse), 32'd0);
    check("reset_rem", 32'(bus.remaining), 32'd0);
    @(negedge clk) reset = 1'b1;
    run(20);
    drive(1'b1, 2'd1, 1'b0);
    step();
    check("load_latency", 32'(bus.pp_status), 32'h2);
    run(12);
    drive(1'b1, 2'd0, 1'b0);
    step();
    run(1);
    drive(1'b1, 2'd2, 1'b0);
    step();
    run(30);
    drive(1'b1, 2'd2, 1'b0);
    step();
    run(3);
    bus.pause = 1'b1;
    held = bus.remaining[11:8];
    run(40);
    check("pause_hold", 32'(bus.remaining[11:8]), 32'(held));
    bus.pause = 1'b0;
    run(30);
    drive(1'b1, 2'd3, 1'b0);
    step();
    for (int k = 0; k < 40 && m_cnt[3] != 1; k++) run(1);
    check("ch3_at_one", 32'(bus.remaining[15:12]), 32'd1);
    drive(1'b1, 2'd3, 1'b0);
    step();
    check("reeat_value", 32'(bus.remaining[15:12]), EXT ? 32'd5 : 32'd4);
    check("reeat_no_pulse", 32'(bus.expire_pulse), 32'd0);
    run(30);
    drive(1'b1, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'd3, 1'b0);
    step();
    run(2);
    drive(1'b1, 2'd1, 1'b1);
    step();
    check("clear_all_pp", 32'(bus.pp_status), 32'd0);
    run(10);
    drive(1'b1, 2'd0, 1'b0);
    repeat (6) step();
    run(20);
    drive(1'b1, 2'd2, 1'b0);
    step();
    run(5);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pp", 32'(bus.pp_status), 32'd0);
    check("async_rst_rem", 32'(bus.remaining), 32'd0);
    check("async_rst_ex", 32'(bus.expire_pulse), 32'd0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    run(25);
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 30) == 0);
      if ($urandom_range(0, 15) == 0) bus.pause = ~bus.pause;
      step();
    end
    bus.pause = 1'b0;
    run(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
